mem_bus_arbiter: RTL and testbench
==================================

# mem_bus_arbiter

Two-master, one-slave arbiter for the data-memory/peripheral bus (`MemAddr`/`MemRead`/`MemWrite`/`MemWriteData`/`MemReadData`) between `pipeline_core` and `Peripheral`. Master 0 is the pipeline core's data port. Master 1 is a secondary bus master, such as a UART program loader or a DMA engine. The block grants the bus with round-robin priority and bounded bursts, returns per-master acknowledges, and provides a stall for the core while it is not granted.

## Interface
Parameters:
- `MAX_BURST`, default 4: maximum back-to-back transfers per grant when the other master is waiting. Legal range 1..15.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `m0_req`, `m1_req`  in  1  master requests a transfer this cycle.
- `m0_rd`, `m1_rd`  in  1  read strobe.
- `m0_wr`, `m1_wr`  in  1  write strobe.
- `m0_addr`, `m1_addr`  in  32  byte address.
- `m0_wdata`, `m1_wdata`  in  32  write data.
- `m0_rdata`, `m1_rdata`  out  32  read data, valid only in that master's ack cycle.
- `m0_ack`, `m1_ack`  out  1  transfer completed this cycle.
- `m0_stall`  out  1  `m0_req & ~m0_ack`, for the pipeline core.
- `s_rd`, `s_wr`  out  1  slave strobes to `Peripheral`.
- `s_addr`, `s_wdata`  out  32  slave address and write data.
- `s_rdata`  in  32  slave read data, combinational and same-cycle.
- `bus_err`  out  1  sticky protocol-error flag.

## Operation
- FSM states:
  - IDLE: no master granted.
  - G0: master 0 owns the bus.
  - G1: master 1 owns the bus.
- State and `last` are registered.
- `last` is a one-bit pointer to the most recently granted master.
- `cnt` is a 4-bit count of transfers in the current grant.
- IDLE transitions:
  - Only m0 requesting → G0.
  - Only m1 requesting → G1.
  - Both requesting → grant the master with index `~last`.
  - No request → stay in IDLE.
- G0 transitions (G1 is symmetric):
  - `m0_req=1` and (`m1_req=0` or `cnt<MAX_BURST-1`) → stay in G0; `cnt++`, saturating at 15.
  - `m0_req=1`, `m1_req=1` and `cnt>=MAX_BURST-1` → G1; `cnt=0`.
  - `m0_req=0` → G1 if `m1_req`, else IDLE; `cnt=0`.
- On entering Gx, `last` is set to x.
- Acknowledge: `m0_ack = (state==G0) & m0_req`, and likewise for m1. Both acks are combinational from state and request.
- Slave drive in Gx when `mx_req`:
  - `s_addr = mx_addr`, `s_wdata = mx_wdata`.
  - `s_wr = mx_wr`, `s_rd = mx_rd & ~mx_wr`.
- Slave drive otherwise: all slave outputs are 0.
- Read data: `m0_rdata = m1_rdata = s_rdata`.
- Protocol error:
  - A granted master with `rd & wr` both high has write priority.
  - That cycle sets `bus_err`.
  - `bus_err` clears only on reset.
- A request with neither `rd` nor `wr` still consumes a transfer slot and is acked; no slave strobe is issued.

## Timing
- Reset is asynchronous (`reset=0`):
  - state=IDLE, `cnt=0`, `last=1` (so m0 wins the first tie), `bus_err=0`.
  - All acks and slave strobes are 0 immediately.
- Reset mid-transfer drops the strobe in the same cycle. The transfer is not acked.
- Latency from IDLE: a request in cycle N is acked in cycle N+1.
- Throughput in a held grant: one transfer per cycle.
- Grant handover: the last transfer of the outgoing master is in cycle N; the new master is acked in cycle N+1. No dead cycle.
- `MAX_BURST=1`: strict alternation while both masters request.
- Requesters must hold `req`, `addr`, `wdata`, `rd` and `wr` stable until ack.

## Test plan
- Reset, then `m0_req=1` with a read of 0x40000010 → `m0_ack=1` one cycle later, `s_rd=1`, `s_addr=0x40000010`, `m0_rdata=s_rdata`.
- Both masters request continuously with `MAX_BURST=4` → grant pattern is m0×4, m1×4, m0×4, with no idle cycles; `m0_stall=1` exactly during the m1 grants.
- From IDLE, both masters raise `req` in the same cycle after reset → m0 granted first. On the next simultaneous request from IDLE after m0 finished, m1 is granted.
- m1 writes 0xDEADBEEF to 0x00000020 while m0 is idle → `s_wr=1`, `s_wdata=0xDEADBEEF` for one cycle; `m1_ack=1`; `bus_err=0`.
- Granted master asserts `rd=wr=1` → `s_wr=1`, `s_rd=0`, `bus_err=1`, which stays 1 until `reset=0`.
- Assert `reset=0` asynchronously mid-burst in G1 → `s_wr`, `s_rd` and `m1_ack` drop to 0 immediately. After release with only m0 requesting, m0 is granted one cycle later.

Source files
------------

// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the two requesting masters, the arbiter and the
// peripheral slave port.
//   m0_* / m1_*   : request side (req, rd, wr, addr, wdata in; rdata, ack out)
//   m0_stall      : core stall, high while m0 requests without being acked
//   s_*           : peripheral side (rd, wr, addr, wdata out; rdata in)
//   bus_err       : sticky protocol-error flag
// Modports:
//   slave  : the arbiter's view (serves the masters, drives the peripheral)
//   master : the requesters'/environment's view
interface mem_bus_arbiter_if;
    logic        m0_req;
    logic        m0_rd;
    logic        m0_wr;
    logic [31:0] m0_addr;
    logic [31:0] m0_wdata;
    logic [31:0] m0_rdata;
    logic        m0_ack;
    logic        m0_stall;

    logic        m1_req;
    logic        m1_rd;
    logic        m1_wr;
    logic [31:0] m1_addr;
    logic [31:0] m1_wdata;
    logic [31:0] m1_rdata;
    logic        m1_ack;

    logic        s_rd;
    logic        s_wr;
    logic [31:0] s_addr;
    logic [31:0] s_wdata;
    logic [31:0] s_rdata;
    logic        bus_err;

    modport slave (
        input  m0_req, m0_rd, m0_wr, m0_addr, m0_wdata,
        input  m1_req, m1_rd, m1_wr, m1_addr, m1_wdata,
        input  s_rdata,
        output m0_rdata, m0_ack, m0_stall,
        output m1_rdata, m1_ack,
        output s_rd, s_wr, s_addr, s_wdata,
        output bus_err
    );

    modport master (
        output m0_req, m0_rd, m0_wr, m0_addr, m0_wdata,
        output m1_req, m1_rd, m1_wr, m1_addr, m1_wdata,
        output s_rdata,
        input  m0_rdata, m0_ack, m0_stall,
        input  m1_rdata, m1_ack,
        input  s_rd, s_wr, s_addr, s_wdata,
        input  bus_err
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-master / one-slave arbiter for the data-memory/peripheral bus.
// Master 0 is the pipeline core data port, master 1 a secondary master
// (loader / DMA). Round-robin grant with bursts bounded to MAX_BURST
// transfers while the other master waits; acks are same-cycle.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : mem_bus_arbiter_if.slave (master request/ack side, slave side,
//           m0_stall and sticky bus_err)
module mem_bus_arbiter #(
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    mem_bus_arbiter_if.slave      bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G0   = 2'd1,
        G1   = 2'd2
    } state_t;

    // cnt value at which the current burst must yield to a waiting master
    localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);

    state_t      state_r;
    state_t      state_nxt_s;
    logic [3:0]  cnt_r;
    logic [3:0]  cnt_nxt_s;
    logic        last_r;
    logic        last_nxt_s;
    logic        bus_err_r;
    logic        g0_s;
    logic        g1_s;
    logic        err_s;

    // A transfer happens whenever the owner of the grant is requesting
    assign g0_s  = (state_r == G0) && bus.m0_req;
    assign g1_s  = (state_r == G1) && bus.m1_req;
    assign err_s = (g0_s && bus.m0_rd && bus.m0_wr) ||
                   (g1_s && bus.m1_rd && bus.m1_wr);

    // State, burst counter and round-robin pointer registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
            cnt_r   <= 4'd0;
            last_r  <= 1'b1;   // m0 wins the first tie
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            last_r  <= last_nxt_s;
        end
    end

    // Sticky protocol-error flag, cleared only by reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus_err_r <= 1'b0;
        end else if (err_s) begin
            bus_err_r <= 1'b1;
        end else begin
            bus_err_r <= bus_err_r;
        end
    end

    // Next-state: grant selection, burst bounding and handover
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        last_nxt_s  = last_r;
        case (state_r)
            IDLE: begin
                // On a tie the master that was not granted last goes first
                if (bus.m0_req && (!bus.m1_req || last_r)) begin
                    state_nxt_s = G0;
                    cnt_nxt_s   = 4'd0;
                    last_nxt_s  = 1'b0;
                end else if (bus.m1_req) begin
                    state_nxt_s = G1;
                    cnt_nxt_s   = 4'd0;
                    last_nxt_s  = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            G0: begin
                if (bus.m0_req) begin
                    if (bus.m1_req && (cnt_r >= BURST_LAST)) begin
                        state_nxt_s = G1;
                        cnt_nxt_s   = 4'd0;
                        last_nxt_s  = 1'b1;
                    end else if (cnt_r != 4'd15) begin
                        cnt_nxt_s = cnt_r + 4'd1;
                    end else begin
                        cnt_nxt_s = cnt_r;
                    end
                end else if (bus.m1_req) begin
                    state_nxt_s = G1;
                    cnt_nxt_s   = 4'd0;
                    last_nxt_s  = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                    cnt_nxt_s   = 4'd0;
                end
            end
            G1: begin
                if (bus.m1_req) begin
                    if (bus.m0_req && (cnt_r >= BURST_LAST)) begin
                        state_nxt_s = G0;
                        cnt_nxt_s   = 4'd0;
                        last_nxt_s  = 1'b0;
                    end else if (cnt_r != 4'd15) begin
                        cnt_nxt_s = cnt_r + 4'd1;
                    end else begin
                        cnt_nxt_s = cnt_r;
                    end
                end else if (bus.m0_req) begin
                    state_nxt_s = G0;
                    cnt_nxt_s   = 4'd0;
                    last_nxt_s  = 1'b0;
                end else begin
                    state_nxt_s = IDLE;
                    cnt_nxt_s   = 4'd0;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = 4'd0;
            end
        endcase
    end

    // Slave-side mux; write wins over read when both strobes are set
    always_comb begin
        bus.s_rd    = 1'b0;
        bus.s_wr    = 1'b0;
        bus.s_addr  = 32'd0;
        bus.s_wdata = 32'd0;
        if (g0_s) begin
            bus.s_addr  = bus.m0_addr;
            bus.s_wdata = bus.m0_wdata;
            bus.s_wr    = bus.m0_wr;
            bus.s_rd    = bus.m0_rd & ~bus.m0_wr;
        end else if (g1_s) begin
            bus.s_addr  = bus.m1_addr;
            bus.s_wdata = bus.m1_wdata;
            bus.s_wr    = bus.m1_wr;
            bus.s_rd    = bus.m1_rd & ~bus.m1_wr;
        end else begin
            bus.s_rd    = 1'b0;
            bus.s_wr    = 1'b0;
            bus.s_addr  = 32'd0;
            bus.s_wdata = 32'd0;
        end
    end

    assign bus.m0_ack   = g0_s;
    assign bus.m1_ack   = g1_s;
    assign bus.m0_stall = bus.m0_req & ~g0_s;
    assign bus.m0_rdata = bus.s_rdata;
    assign bus.m1_rdata = bus.s_rdata;
    assign bus.bus_err  = bus_err_r;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;

    logic clk;
    logic reset;

    mem_bus_arbiter_if bus ();

    mem_bus_arbiter #(.MAX_BURST(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // flags = {m0_ack, m1_ack, m0_stall, s_rd, s_wr, bus_err}
    typedef struct {
        bit          rst;
        logic        q0, r0, w0;
        logic [31:0] a0, d0;
        logic        q1, r1, w1;
        logic [31:0] a1, d1;
        logic [5:0]  f;
        logic [31:0] ea, ew;
        string       tag;
    } vec_t;

    typedef struct packed {
        logic        mst;
        logic [31:0] addr;
        logic [31:0] rdata;
    } sb_t;

    vec_t vt[$];
    sb_t  sb[$];
    sb_t  mon_e;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [5:0] flags_now();
        return {bus.m0_ack, bus.m1_ack, bus.m0_stall, bus.s_rd, bus.s_wr, bus.bus_err};
    endfunction

    function automatic vec_t mk(bit rst,
                                logic q0, logic r0, logic w0, logic [31:0] a0, logic [31:0] d0,
                                logic q1, logic r1, logic w1, logic [31:0] a1, logic [31:0] d1,
                                logic [5:0] f, logic [31:0] ea, logic [31:0] ew, string tag);
        vec_t v;
        v.rst = rst;
        v.q0 = q0; v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
        v.q1 = q1; v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
        v.f = f; v.ea = ea; v.ew = ew; v.tag = tag;
        return v;
    endfunction

    task automatic drive_idle();
        bus.m0_req = 1'b0; bus.m0_rd = 1'b0; bus.m0_wr = 1'b0;
        bus.m0_addr = 32'd0; bus.m0_wdata = 32'd0;
        bus.m1_req = 1'b0; bus.m1_rd = 1'b0; bus.m1_wr = 1'b0;
        bus.m1_addr = 32'd0; bus.m1_wdata = 32'd0;
        bus.s_rdata = 32'd0;
    endtask

    // Asynchronous reset pulse placed between clock edges
    task automatic do_reset();
        drive_idle();
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("rst_flags", {26'd0, flags_now()}, 32'd0);
        chk("rst_saddr", bus.s_addr, 32'd0);
        #1;
        reset = 1'b1;
    endtask

    // Scoreboard monitor: every ack pops one expected transfer
    always @(negedge clk) begin
        if (bus.m0_ack || bus.m1_ack) begin
            chk("dual_ack", {31'd0, bus.m0_ack & bus.m1_ack}, 32'd0);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: ack m0=%0d m1=%0d with empty queue", bus.m0_ack, bus.m1_ack);
            end else begin
                mon_e = sb.pop_front();
                chk("sb_master", {31'd0, bus.m1_ack}, {31'd0, mon_e.mst});
                chk("sb_addr", bus.s_addr, mon_e.addr);
                chk("sb_rdata", mon_e.mst ? bus.m1_rdata : bus.m0_rdata, mon_e.rdata);
            end
        end
    end

    initial begin
        logic [31:0] rd;
        clk   = 1'b0;
        reset = 1'b0;
        drive_idle();

        // m0 read after reset
        vt.push_back(mk(1, 1,1,0,32'h4000_0010,32'd0, 0,0,0,32'd0,32'd0, 6'b001000, 32'd0,32'd0, "rd_wait"));
        vt.push_back(mk(0, 1,1,0,32'h4000_0010,32'd0, 0,0,0,32'd0,32'd0, 6'b100100, 32'h4000_0010,32'd0, "rd_ack"));
        vt.push_back(mk(0, 0,0,0,32'd0,32'd0, 0,0,0,32'd0,32'd0, 6'b000000, 32'd0,32'd0, "rd_done"));
        // tie after reset -> m0, next tie from IDLE -> m1
        vt.push_back(mk(1, 1,1,0,32'h100,32'd0, 1,1,0,32'h200,32'd0, 6'b001000, 32'd0,32'd0, "tie_idle"));
        vt.push_back(mk(0, 1,1,0,32'h100,32'd0, 0,0,0,32'd0,32'd0, 6'b100100, 32'h100,32'd0, "tie_m0"));
        vt.push_back(mk(0, 0,0,0,32'd0,32'd0, 0,0,0,32'd0,32'd0, 6'b000000, 32'd0,32'd0, "tie_drop"));
        vt.push_back(mk(0, 1,1,0,32'h104,32'd0, 1,1,0,32'h204,32'd0, 6'b001000, 32'd0,32'd0, "tie2_idle"));
        vt.push_back(mk(0, 1,1,0,32'h104,32'd0, 1,1,0,32'h204,32'd0, 6'b011100, 32'h204,32'd0, "tie2_m1"));
        vt.push_back(mk(0, 0,0,0,32'd0,32'd0, 0,0,0,32'd0,32'd0, 6'b000000, 32'd0,32'd0, "tie2_drop"));
        // continuous contention: m0 x4, m1 x4, m0 x4
        vt.push_back(mk(1, 1,1,0,32'h1000,32'd0, 1,0,1,32'h2000,32'hA5A5_A5A5, 6'b001000, 32'd0,32'd0, "burst_idle"));
        for (int k = 0; k < 12; k++) begin
            if (((k / 4) % 2) == 0)
                vt.push_back(mk(0, 1,1,0,32'h1000,32'd0, 1,0,1,32'h2000,32'hA5A5_A5A5, 6'b100100, 32'h1000,32'd0, "burst_m0"));
            else
                vt.push_back(mk(0, 1,1,0,32'h1000,32'd0, 1,0,1,32'h2000,32'hA5A5_A5A5, 6'b011010, 32'h2000,32'hA5A5_A5A5, "burst_m1"));
        end
        vt.push_back(mk(0, 0,0,0,32'd0,32'd0, 0,0,0,32'd0,32'd0, 6'b000000, 32'd0,32'd0, "burst_end"));
        // m1 write with m0 idle
        vt.push_back(mk(1, 0,0,0,32'd0,32'd0, 1,0,1,32'h20,32'hDEAD_BEEF, 6'b000000, 32'd0,32'd0, "wr_idle"));
        vt.push_back(mk(0, 0,0,0,32'd0,32'd0, 1,0,1,32'h20,32'hDEAD_BEEF, 6'b010010, 32'h20,32'hDEAD_BEEF, "wr_ack"));
        vt.push_back(mk(0, 0,0,0,32'd0,32'd0, 0,0,0,32'd0,32'd0, 6'b000000, 32'd0,32'd0, "wr_done"));
        // rd=wr=1 protocol error, then sticky flag and strobe-less transfer
        vt.push_back(mk(0, 1,1,1,32'h30,32'h1111_2222, 0,0,0,32'd0,32'd0, 6'b001000, 32'd0,32'd0, "err_idle"));
        vt.push_back(mk(0, 1,1,1,32'h30,32'h1111_2222, 0,0,0,32'd0,32'd0, 6'b100010, 32'h30,32'h1111_2222, "err_ack"));
        vt.push_back(mk(0, 0,0,0,32'd0,32'd0, 0,0,0,32'd0,32'd0, 6'b000001, 32'd0,32'd0, "err_set"));
        vt.push_back(mk(0, 0,0,0,32'd0,32'd0, 1,1,0,32'h44,32'd0, 6'b000001, 32'd0,32'd0, "err_m1_idle"));
        vt.push_back(mk(0, 0,0,0,32'd0,32'd0, 1,1,0,32'h44,32'd0, 6'b010101, 32'h44,32'd0, "err_m1_ack"));
        vt.push_back(mk(0, 0,0,0,32'd0,32'd0, 0,0,0,32'd0,32'd0, 6'b000001, 32'd0,32'd0, "err_m1_done"));
        vt.push_back(mk(0, 1,0,0,32'h50,32'd0, 0,0,0,32'd0,32'd0, 6'b001001, 32'd0,32'd0, "nop_idle"));
        vt.push_back(mk(0, 1,0,0,32'h50,32'd0, 0,0,0,32'd0,32'd0, 6'b100001, 32'h50,32'd0, "nop_ack"));
        vt.push_back(mk(0, 0,0,0,32'd0,32'd0, 0,0,0,32'd0,32'd0, 6'b000001, 32'd0,32'd0, "nop_done"));

        for (int i = 0; i < vt.size(); i++) begin
            if (vt[i].rst) do_reset();
            @(posedge clk);
            #1;
            rd = 32'h5A00_0000 | 32'(i);
            bus.m0_req = vt[i].q0; bus.m0_rd = vt[i].r0; bus.m0_wr = vt[i].w0;
            bus.m0_addr = vt[i].a0; bus.m0_wdata = vt[i].d0;
            bus.m1_req = vt[i].q1; bus.m1_rd = vt[i].r1; bus.m1_wr = vt[i].w1;
            bus.m1_addr = vt[i].a1; bus.m1_wdata = vt[i].d1;
            bus.s_rdata = rd;
            if (vt[i].f[5]) sb.push_back({1'b0, vt[i].ea, rd});
            if (vt[i].f[4]) sb.push_back({1'b1, vt[i].ea, rd});
            @(negedge clk);
            chk({vt[i].tag, "_flags"}, {26'd0, flags_now()}, {26'd0, vt[i].f});
            chk({vt[i].tag, "_saddr"}, bus.s_addr, vt[i].ea);
            chk({vt[i].tag, "_swdata"}, bus.s_wdata, vt[i].ew);
        end

        // bus_err stays set while idle
        @(negedge clk);
        chk("err_sticky", {31'd0, bus.bus_err}, 32'd1);

        // async reset in the middle of an m1 burst
        do_reset();
        @(posedge clk);
        #1;
        bus.m1_req = 1'b1; bus.m1_wr = 1'b1;
        bus.m1_addr = 32'h60; bus.m1_wdata = 32'hCAFE_F00D;
        bus.s_rdata = 32'd0;
        sb.push_back({1'b1, 32'h60, 32'd0});
        @(negedge clk);
        chk("g1_wait", {31'd0, bus.m1_ack}, 32'd0);
        @(negedge clk);
        chk("g1_ack_wr", {30'd0, bus.m1_ack, bus.s_wr}, 32'd3);
        #2;
        reset = 1'b0;
        #1;
        chk("rst_mid_drop", {28'd0, bus.s_wr, bus.s_rd, bus.m1_ack, bus.m0_ack}, 32'd0);
        chk("rst_mid_err", {31'd0, bus.bus_err}, 32'd0);
        bus.m1_req = 1'b0; bus.m1_wr = 1'b0;
        bus.m0_req = 1'b1; bus.m0_rd = 1'b1; bus.m0_addr = 32'h70;
        bus.s_rdata = 32'h77;
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        sb.push_back({1'b0, 32'h70, 32'h77});
        @(negedge clk);
        chk("post_rst_m0", {30'd0, bus.m0_ack, bus.s_rd}, 32'd3);
        chk("post_rst_addr", bus.s_addr, 32'h70);
        @(posedge clk);
        #1;
        drive_idle();
        @(negedge clk);
        @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
